// File: rtl/dma_protocol_monitor.sv
// dma_protocol_monitor: run-time checker for DMA controller state sequencing, DREQ/DACK handshake and arbitration
module dma_protocol_monitor #(
    parameter int NUM_CH  = 4,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              CS_N,
    input  logic [NUM_CH-1:0] DREQ,
    input  logic [NUM_CH-1:0] DACK,
    input  logic [5:0]        state,
    input  logic              priorityType,
    input  logic              clearErr,
    output logic [5:0]        errFlags,
    output logic [CNT_W-1:0]  errCount,
    output logic [2:0]        firstErrCode,
    output logic              firstErrValid
);
    localparam int LG_W = $clog2(NUM_CH);
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [5:0] SI = 6'b000001;
    localparam logic [5:0] SO = 6'b000010;
    localparam logic [5:0] S1 = 6'b000100;
    localparam logic [5:0] S2 = 6'b001000;
    localparam logic [5:0] S3 = 6'b010000;
    localparam logic [5:0] S4 = 6'b100000;

    logic [5:0]        prev_state_q, prev_state_d;
    logic              prev_valid_q, prev_valid_d;
    logic [NUM_CH-1:0] prev_dack_q, prev_dack_d;
    logic [NUM_CH-1:0] prev_dreq_q, prev_dreq_d;
    logic [TO_W-1:0]   cnt_q [NUM_CH];
    logic [TO_W-1:0]   cnt_d [NUM_CH];
    logic [LG_W-1:0]   last_grant_q, last_grant_d;
    logic              reset_seen_q, reset_seen_d;
    logic [5:0]        err_flags_q, err_flags_d;
    logic [CNT_W-1:0]  err_count_q, err_count_d;
    logic [2:0]        first_code_q, first_code_d;
    logic              first_valid_q, first_valid_d;

    logic [5:0]        legal_next, viol;
    logic              state_onehot, dack_multi, dack_onehot, dack_rise, timeout_hit;
    logic [LG_W-1:0]   grant, expected;

    // Per-cycle violation detection; the RESET cycle itself is gated by the register update
    always_comb begin
        legal_next = prev_state_q == SI ? (SI | SO) :
                     prev_state_q == SO ? (SO | S1) :
                     prev_state_q == S1 ? S2 :
                     prev_state_q == S2 ? (S3 | S4) :
                     prev_state_q == S3 ? S4 :
                     prev_state_q == S4 ? SI : 6'b000000;
        state_onehot = state != '0 && (state & (state - 6'd1)) == '0;
        dack_multi   = (DACK & (DACK - NUM_CH'(1))) != '0;
        dack_onehot  = DACK != '0 && !dack_multi;
        dack_rise    = prev_dack_q == '0 && dack_onehot;
        grant = '0;
        for (int i = 0; i < NUM_CH; i++)
            if (DACK[i]) grant = LG_W'(i);
        expected = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            automatic int idx = ((priorityType ? int'(last_grant_q) + 1 : 0) + k) % NUM_CH;
            if (prev_dreq_q[LG_W'(idx)]) expected = LG_W'(idx);
        end
        timeout_hit = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i] = (!DREQ[i] || DACK[i]) ? '0 :
                       cnt_q[i] == TO_W'(TIMEOUT) ? cnt_q[i] : cnt_q[i] + TO_W'(1);
            if (cnt_q[i] != TO_W'(TIMEOUT) && cnt_d[i] == TO_W'(TIMEOUT)) timeout_hit = 1'b1;
        end
        viol[0] = !CS_N && prev_valid_q && !(state_onehot && (state & legal_next) != '0);
        viol[1] = !CS_N && (!state_onehot || dack_multi);
        viol[2] = !CS_N && reset_seen_q && (state != SI || DACK != '0);
        viol[3] = !CS_N && dack_rise && (DACK & prev_dreq_q) != '0 && grant != expected;
        viol[4] = !CS_N && timeout_hit;
        viol[5] = !CS_N && dack_rise && (DACK & prev_dreq_q) == '0;
    end

    // Error reporting: clearErr wipes the old record but keeps this cycle's violations
    always_comb begin
        automatic logic [5:0]       flags_base = clearErr ? '0 : err_flags_q;
        automatic logic [CNT_W-1:0] count_base = clearErr ? '0 : err_count_q;
        automatic logic [2:0]       code_base  = clearErr ? '0 : first_code_q;
        automatic logic             valid_base = clearErr ? 1'b0 : first_valid_q;
        automatic logic [2:0]       low        = '0;
        for (int i = 5; i >= 0; i--)
            if (viol[i]) low = 3'(i);
        err_flags_d   = flags_base | viol;
        err_count_d   = (viol != '0 && count_base != '1) ? count_base + CNT_W'(1) : count_base;
        first_code_d  = (viol != '0 && !valid_base) ? low : code_base;
        first_valid_d = valid_base || viol != '0;
        prev_state_d  = state;
        prev_valid_d  = !CS_N;
        prev_dack_d   = DACK;
        prev_dreq_d   = DREQ;
        last_grant_d  = dack_rise ? grant : last_grant_q;
        reset_seen_d  = 1'b0;
    end

    // All tracking and reporting state, synchronously reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            prev_state_q  <= SI;
            prev_valid_q  <= 1'b1;
            prev_dack_q   <= '0;
            prev_dreq_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
            last_grant_q  <= LG_W'(NUM_CH - 1);
            reset_seen_q  <= 1'b1;
            err_flags_q   <= '0;
            err_count_q   <= '0;
            first_code_q  <= '0;
            first_valid_q <= 1'b0;
        end else begin
            prev_state_q  <= prev_state_d;
            prev_valid_q  <= prev_valid_d;
            prev_dack_q   <= prev_dack_d;
            prev_dreq_q   <= prev_dreq_d;
            for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
            last_grant_q  <= last_grant_d;
            reset_seen_q  <= reset_seen_d;
            err_flags_q   <= err_flags_d;
            err_count_q   <= err_count_d;
            first_code_q  <= first_code_d;
            first_valid_q <= first_valid_d;
        end
    end

    assign errFlags      = err_flags_q;
    assign errCount      = err_count_q;
    assign firstErrCode  = first_code_q;
    assign firstErrValid = first_valid_q;
endmodule

// File: tb/tb_dma_protocol_monitor.sv
// tb_dma_protocol_monitor: directed plus randomized checking of dma_protocol_monitor against a behavioural model
module tb_dma_protocol_monitor;
    localparam int N  = 4;
    localparam int T  = 16;
    localparam int CW = 8;
    localparam logic [5:0] SI = 6'b000001, SO = 6'b000010, S1 = 6'b000100;
    localparam logic [5:0] S2 = 6'b001000, S3 = 6'b010000, S4 = 6'b100000;

    logic          CLK = 1'b0;
    logic          RESET, CS_N, prio, clr;
    logic [N-1:0]  DREQ, DACK;
    logic [5:0]    st;
    logic [5:0]    errFlags;
    logic [CW-1:0] errCount;
    logic [2:0]    firstErrCode;
    logic          firstErrValid;

    dma_protocol_monitor #(.NUM_CH(N), .TIMEOUT(T), .CNT_W(CW)) dut (
        .CLK(CLK), .RESET(RESET), .CS_N(CS_N), .DREQ(DREQ), .DACK(DACK),
        .state(st), .priorityType(prio), .clearErr(clr),
        .errFlags(errFlags), .errCount(errCount),
        .firstErrCode(firstErrCode), .firstErrValid(firstErrValid)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    int          m_prev_state, m_prev_dack, m_prev_dreq, m_last;
    bit          m_prev_valid, m_rs;
    int          m_cnt [N];
    int          m_flags, m_count, m_code;
    bit          m_valid;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int st_idx(input int s);
        if ($countones(s[5:0]) != 1) return -1;
        for (int i = 0; i < 6; i++) if (s[i]) return i;
        return -1;
    endfunction

    function automatic bit legal(input int p, input int n);
        case (p)
            0: return n == 0 || n == 1;
            1: return n == 1 || n == 2;
            2: return n == 3;
            3: return n == 4 || n == 5;
            4: return n == 5;
            5: return n == 0;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_prev_state = 1; m_prev_valid = 1; m_prev_dack = 0; m_prev_dreq = 0;
        m_last = N - 1; m_rs = 1;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        m_flags = 0; m_count = 0; m_code = 0; m_valid = 0;
    endtask

    task automatic model_step();
        int v = 0;
        int s = st_idx(int'(st));
        int p = st_idx(m_prev_state);
        int dk = int'(DACK);
        int dr = int'(DREQ);
        if (RESET) begin
            model_reset();
            return;
        end
        if (!CS_N) begin
            if (m_prev_valid && !(s >= 0 && p >= 0 && legal(p, s))) v |= 1;
            if (s < 0 || $countones(DACK) > 1) v |= 2;
            if (m_rs && (st != SI || dk != 0)) v |= 4;
        end
        if (m_prev_dack == 0 && $countones(DACK) == 1) begin
            int g = 0;
            for (int i = 0; i < N; i++) if (DACK[i]) g = i;
            if (!CS_N) begin
                if (((m_prev_dreq >> g) & 1) == 0) v |= 32;
                else begin
                    int start = prio ? (m_last + 1) % N : 0;
                    int e = -1;
                    for (int k = 0; k < N && e < 0; k++)
                        if ((m_prev_dreq >> ((start + k) % N)) & 1) e = (start + k) % N;
                    if (e != g) v |= 8;
                end
            end
            m_last = g;
        end
        for (int i = 0; i < N; i++) begin
            if (!DREQ[i] || DACK[i]) m_cnt[i] = 0;
            else if (m_cnt[i] < T) begin
                m_cnt[i]++;
                if (m_cnt[i] == T && !CS_N) v |= 16;
            end
        end
        if (clr) begin
            m_flags = 0; m_count = 0; m_code = 0; m_valid = 0;
        end
        m_flags |= v;
        if (v != 0) begin
            if (m_count < (1 << CW) - 1) m_count++;
            if (!m_valid) begin
                for (int i = 5; i >= 0; i--) if ((v >> i) & 1) m_code = i;
                m_valid = 1;
            end
        end
        m_rs = 0;
        m_prev_state = int'(st); m_prev_valid = !CS_N;
        m_prev_dack = dk; m_prev_dreq = dr;
    endtask

    task automatic cycle();
        model_step();
        @(posedge CLK);
        #1;
        check("flags", int'(errFlags), m_flags);
        check("count", int'(errCount), m_count);
        check("code", int'(firstErrCode), m_code);
        check("valid", int'(firstErrValid), int'(m_valid));
    endtask

    task automatic drive(input logic [5:0] s, input logic [N-1:0] rq, input logic [N-1:0] ak);
        st = s; DREQ = rq; DACK = ak;
        cycle();
    endtask

    function automatic logic [5:0] next_legal(input logic [5:0] s, input bit r);
        case (st_idx(int'(s)))
            0: return r ? SO : SI;
            1: return r ? S1 : SO;
            2: return S2;
            3: return r ? S4 : S3;
            4: return S4;
            5: return SI;
            default: return SI;
        endcase
    endfunction

    initial begin
        logic [5:0] seq [12];
        RESET = 1; CS_N = 0; prio = 0; clr = 0; st = SI; DREQ = '0; DACK = '0;
        model_reset();
        cycle();
        cycle();
        check("rst_flags", int'(errFlags), 0);
        check("rst_count", int'(errCount), 0);
        check("rst_valid", int'(firstErrValid), 0);
        RESET = 0;

        seq = '{SI, SO, S1, S2, S4, SI, SO, S1, S2, S3, S4, SI};
        foreach (seq[i]) drive(seq[i], '0, '0);
        check("legal_flags", int'(errFlags), 0);
        check("legal_count", int'(errCount), 0);

        drive(SO, '0, '0);
        drive(S2, '0, '0);
        check("bad1_flags", int'(errFlags), 1);
        check("bad1_count", int'(errCount), 1);
        check("bad1_code", int'(firstErrCode), 0);
        drive(S3, '0, '0);
        drive(S4, '0, '0);
        drive(S1, '0, '0);
        check("bad2_count", int'(errCount), 2);
        check("bad2_code", int'(firstErrCode), 0);
        drive(S2, '0, '0);
        drive(S4, '0, '0);
        drive(SI, '0, '0);

        clr = 1; drive(SI, '0, '0); clr = 0;
        drive(SI, 4'b0110, '0);
        drive(SI, 4'b0110, 4'b0100);
        check("fixed_bad", int'(errFlags), 8);
        clr = 1; drive(SI, '0, '0); clr = 0;
        check("clear_flags", int'(errFlags), 0);
        drive(SI, 4'b0110, '0);
        drive(SI, 4'b0110, 4'b0010);
        check("fixed_ok", int'(errFlags), 0);

        prio = 1;
        drive(SI, 4'b0011, '0);
        drive(SI, 4'b0011, 4'b0001);
        check("rot_ok", int'(errFlags), 0);
        drive(SI, 4'b0011, '0);
        drive(SI, 4'b0011, 4'b0001);
        check("rot_bad", int'(errFlags), 8);

        clr = 1; drive(SI, '0, '0); clr = 0;
        for (int i = 0; i < T - 1; i++) drive(SI, 4'b0100, '0);
        check("to_early", int'(errFlags), 0);
        drive(SI, 4'b0100, '0);
        check("to_flag", int'(errFlags), 16);
        check("to_count", int'(errCount), 1);
        for (int i = 0; i < 4; i++) drive(SI, 4'b0100, '0);
        check("to_once", int'(errCount), 1);
        drive(SI, '0, 4'b1001);
        check("dack_multi", int'(errFlags[1]), 1);

        clr = 1; drive(SI, '0, '0); clr = 0;
        drive(SO, '0, '0);
        drive(S1, '0, '0);
        drive(S2, '0, '0);
        drive(S2, '0, 4'b0100);
        RESET = 1; drive(S2, '0, '0); RESET = 0;
        check("midrst_flags", int'(errFlags), 0);
        check("midrst_count", int'(errCount), 0);
        drive(S1, '0, '0);
        check("rststate", int'(errFlags[2]), 1);
        drive(S2, '0, '0);
        clr = 1; drive(S3, '0, 4'b0001); clr = 0;
        check("spur_flags", int'(errFlags), 32);
        check("spur_count", int'(errCount), 1);
        check("spur_code", int'(firstErrCode), 5);

        for (int n = 0; n < 3000; n++) begin
            int r = $urandom_range(0, 99);
            st    = r < 88 ? next_legal(st, 1'($urandom)) : 6'($urandom);
            DREQ  = N'($urandom);
            r     = $urandom_range(0, 99);
            DACK  = r < 50 ? '0 : r < 85 ? N'(1) << $urandom_range(0, N - 1) : N'($urandom);
            CS_N  = $urandom_range(0, 99) < 10;
            clr   = $urandom_range(0, 99) < 3;
            RESET = $urandom_range(0, 99) < 1;
            if ($urandom_range(0, 49) == 0) prio = ~prio;
            if (RESET) st = S2;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
